// File: rtl/sw_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debounce_pkg
//  Description : Shared constants for the switch debouncer. Holds the per-bit
//                FSM state encoding, the default timing constants and a
//                helper that sizes the stable-time counter.
//  Revision    : 1.0  initial release
// ============================================================================
package sw_debounce_pkg;

    // Per-bit debounce FSM encoding
    localparam logic [1:0] S_LOW    = 2'd0;
    localparam logic [1:0] S_WAIT_H = 2'd1;
    localparam logic [1:0] S_HIGH   = 2'd2;
    localparam logic [1:0] S_WAIT_L = 2'd3;

    // Defaults: 1 ms stable time at 100 MHz, two-flop synchroniser
    localparam int c_def_cnt_max     = 100000;
    localparam int c_def_sync_stages = 2;

    // Counter width: max(1, clog2(cnt_max)); a single-cycle count still
    // needs one bit to hold the zero it compares against.
    function automatic int cnt_width(input int cnt_max);
        int w;
        w = $clog2(cnt_max);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : sw_debounce_pkg
`default_nettype wire

// File: rtl/sw_debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debounce_bit
//  Description : One switch bit: synchroniser chain, four-state stable-time
//                debounce FSM with counter, registered clean level and an
//                optional one-cycle rising-edge pulse.
//  Ports       : clk     - system clock (rising edge)
//                rst     - synchronous active-high reset
//                i_raw   - asynchronous bouncing switch input
//                o_level - debounced level (flop output)
//                o_rise  - one-cycle pulse on accepted 0->1
//  Config      : SW_EDGE_EN defined builds the rise pulse flop; otherwise
//                o_rise is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int CNT_MAX     = c_def_cnt_max,
    parameter int SYNC_STAGES = c_def_sync_stages
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int              CW         = cnt_width(CNT_MAX);
    localparam logic [CW-1:0]   c_cnt_last = CW'(CNT_MAX - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Synchroniser: shift chain, last stage feeds the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Debounce FSM. A WAIT state accepts the new level only after it has been
    // seen on CNT_MAX further samples; any reversion drops back to the stable
    // state, so the next attempt restarts the count from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            case (r_state)
                S_LOW: begin
                    if (w_sync) begin
                        r_state <= S_WAIT_H;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT_H: begin
                    if (!w_sync) begin
                        r_state <= S_LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= S_HIGH;
                        r_level <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (!w_sync) begin
                        r_state <= S_WAIT_L;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT_L: begin
                    if (w_sync) begin
                        r_state <= S_HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= S_LOW;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_LOW;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign o_level = r_level;

`ifdef SW_EDGE_EN
    logic r_rise;

    // Pulse on the same edge the level is accepted high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rise <= 1'b0;
        end else begin
            r_rise <= (r_state == S_WAIT_H) && w_sync && (r_cnt == c_cnt_last);
        end
    end

    assign o_rise = r_rise;
`else
    assign o_rise = 1'b0;
`endif

endmodule : sw_debounce_bit
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debounce
//  Description : Conditions raw board switches for the LED state machine.
//                Each bit is synchronised, debounced by stable-time counting
//                and registered independently of the others.
//  Ports       : clk     - system clock (rising edge)
//                reset   - synchronous active-high reset
//                sw_raw  - [WIDTH] asynchronous bouncing switch inputs
//                sw_out  - [WIDTH] debounced registered level (to fsm.sw)
//                sw_rise - [WIDTH] one-cycle pulse per accepted 0->1
//  Config      : SW_EDGE_EN defined enables sw_rise; undefined ties it to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int CNT_MAX     = c_def_cnt_max,
    parameter int SYNC_STAGES = c_def_sync_stages
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        sw_debounce_bit #(
            .CNT_MAX     (CNT_MAX),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_bit (
            .clk     (clk),
            .rst     (reset),
            .i_raw   (sw_raw[gi]),
            .o_level (sw_out[gi]),
            .o_rise  (sw_rise[gi])
        );
    end

endmodule : sw_debounce
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sw_debounce
//  Description : Self-checking bench for sw_debounce. A reference model
//                tracks the sample stream the debouncer sees and accepts a
//                new level once it has been present for CNT_MAX+1 successive
//                samples since the last reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sw_debounce;

    localparam int WIDTH       = 3;
    localparam int CNT_MAX     = 4;
    localparam int SYNC_STAGES = 2;
    localparam int WIN         = CNT_MAX + 1;

`ifdef SW_EDGE_EN
    localparam bit c_edge = 1'b1;
`else
    localparam bit c_edge = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] sw_raw = '0;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] sw_rise;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [WIDTH-1:0] m_pipe [SYNC_STAGES];
    logic [WIDTH-1:0] m_hist [$];
    logic [WIDTH-1:0] m_out;
    logic [WIDTH-1:0] m_rise;

    always #5 clk = ~clk;

    sw_debounce #(
        .WIDTH       (WIDTH),
        .CNT_MAX     (CNT_MAX),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw_raw  (sw_raw),
        .sw_out  (sw_out),
        .sw_rise (sw_rise)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Advance the model by one clock edge using the inputs present at it
    task automatic model_edge(input logic r, input logic [WIDTH-1:0] raw);
        logic [WIDTH-1:0] samp;
        logic             all_diff;
        m_rise = '0;
        if (r) begin
            for (int j = 0; j < SYNC_STAGES; j++) m_pipe[j] = '0;
            m_hist.delete();
            m_out = '0;
        end else begin
            samp = m_pipe[SYNC_STAGES-1];
            for (int j = SYNC_STAGES-1; j > 0; j--) m_pipe[j] = m_pipe[j-1];
            m_pipe[0] = raw;
            m_hist.push_back(samp);
            if (m_hist.size() > WIN) void'(m_hist.pop_front());
            if (m_hist.size() == WIN) begin
                for (int b = 0; b < WIDTH; b++) begin
                    all_diff = 1'b1;
                    foreach (m_hist[k]) if (m_hist[k][b] == m_out[b]) all_diff = 1'b0;
                    if (all_diff) begin
                        if (!m_out[b]) m_rise[b] = 1'b1;
                        m_out[b] = ~m_out[b];
                    end
                end
            end
        end
    endtask

    // One clock: drive on the falling edge, compare 1 ns after the rising edge
    task automatic step(input logic r, input logic [WIDTH-1:0] raw, input string tag);
        @(negedge clk);
        reset  = r;
        sw_raw = raw;
        @(posedge clk);
        model_edge(r, raw);
        #1;
        check({tag, "_out"}, 32'(sw_out), 32'(m_out));
        check({tag, "_rise"}, 32'(sw_rise), c_edge ? 32'(m_rise) : 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] raw;
        for (int j = 0; j < SYNC_STAGES; j++) m_pipe[j] = '0;
        m_out  = '0;
        m_rise = '0;

        // 1: reset held with all switches high, then full debounce
        for (int i = 0; i < 3; i++) step(1'b1, 3'b111, "t1_rst");
        step(1'b0, 3'b111, "t1_rel");
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 3'b111, "t1");
            if (i == 5) check("t1_pre", 32'(sw_out), 32'h0);
            if (i == 6) check("t1_lat", 32'(sw_out), 32'h7);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 3'b000, "rst");

        // 2: clean press on bit0
        for (int i = 0; i < 10; i++) step(1'b0, 3'b001, "t2");

        // 3: bounce on bit1 then held high
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 3'b011, "t3_g");
            step(1'b0, 3'b011, "t3_g");
            step(1'b0, 3'b001, "t3_g");
        end
        for (int i = 0; i < 10; i++) step(1'b0, 3'b011, "t3");
        check("t3_hi", 32'(sw_out), 32'h3);

        // 4: low glitch while high, then release of bit0
        step(1'b0, 3'b010, "t4_g");
        step(1'b0, 3'b010, "t4_g");
        for (int i = 0; i < 8; i++) step(1'b0, 3'b011, "t4_h");
        check("t4_glitch", 32'(sw_out), 32'h3);
        for (int i = 0; i < 10; i++) step(1'b0, 3'b010, "t4");
        check("t4_rel", 32'(sw_out), 32'h2);

        // 5: simultaneous press from all-low
        for (int i = 0; i < 10; i++) step(1'b0, 3'b000, "t5_lo");
        for (int i = 0; i < 10; i++) step(1'b0, 3'b111, "t5");
        for (int i = 0; i < 10; i++) step(1'b0, 3'b000, "t5_lo");

        // 6: reset while bit2 mid-count, input held high
        for (int i = 0; i < 5; i++) step(1'b0, 3'b100, "t6_w");
        check("t6_wait", 32'(sw_out), 32'h0);
        for (int i = 0; i < 2; i++) step(1'b1, 3'b100, "t6_rst");
        step(1'b0, 3'b100, "t6_rel");
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 3'b100, "t6");
            if (i == 5) check("t6_pre", 32'(sw_out), 32'h0);
            if (i == 6) check("t6_lat", 32'(sw_out), 32'h4);
        end

        // Randomised: sticky inputs with occasional flips and rare resets
        raw = '0;
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < WIDTH; b++)
                if ($urandom_range(0, 5) == 0) raw[b] = ~raw[b];
            step(($urandom_range(0, 199) == 0), raw, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog against a stalled run
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_sw_debounce
`default_nettype wire
